// File: rtl/reg_writeback_pkg.sv
// Shared types and helpers for the register writeback stage.
package wb_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned RD_W  = $clog2(NREGS);

    // One buffered register write: destination and value.
    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // One-hot store strobe for a destination register.
    function automatic logic [NREGS-1:0] onehot_rd(input logic [RD_W-1:0] rd);
        return NREGS'(1) << rd;
    endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Request/writeback bus of the register writeback stage.
// slave: the writeback stage; master: the ALU/load-unit/register side.
interface reg_writeback_if
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             alu_valid;
    logic             alu_ready;
    logic [RD_W-1:0]  alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             ld_valid;
    logic             ld_ready;
    logic [RD_W-1:0]  ld_rd;
    logic [XLEN-1:0]  ld_data;
    logic             hold;
    logic [NREGS-1:0] store;
    logic [XLEN-1:0]  data;
    logic [NREGS-1:0] pending;
    logic [CNT_W-1:0] count;

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, hold,
        output alu_ready, ld_ready, store, data, pending, count
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, hold,
        input  alu_ready, ld_ready, store, data, pending, count
    );

endinterface

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: synchronous FIFO of wb_req_t with occupancy and entry visibility.
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  wb_req_t               i_wdata,
    input  logic                  i_pop,
    output wb_req_t               o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output wb_req_t [DEPTH-1:0]   o_mem,
    output logic [DEPTH-1:0]      o_valid
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_req_t [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                w_push;
    logic                w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_mem   = r_mem;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Entry storage; contents are don't-care until marked valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        o_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_valid[i] = CNT_W'(PTR_W'(PTR_W'(i) - r_rd_ptr)) < r_count;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: arbitrates ALU/load writes into a FIFO and drains one write
// per cycle as a one-hot store strobe plus data, exporting a pending mask.
// Optional macro REG_WRITEBACK_BYPASS_EN: a write accepted while the FIFO is
// empty and hold is low skips the FIFO and strobes one edge earlier.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    reg_writeback_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                w_full;
    logic                w_empty;
    logic                w_ld_acc;
    logic                w_alu_acc;
    logic                w_wr;
    logic                w_pop;
    logic                w_push;
    logic                w_byp;
    wb_req_t             w_req;
    wb_req_t             w_head;
    wb_req_t [DEPTH-1:0] w_fifo_mem;
    logic [DEPTH-1:0]    w_fifo_valid;
    logic [CNT_W-1:0]    w_count;
    logic [NREGS-1:0]    w_fifo_mask;
    logic [NREGS-1:0]    r_store;
    logic [XLEN-1:0]     r_data;
    logic [NREGS-1:0]    r_pending;

    // Ready depends only on registered occupancy; load unit has priority.
    assign bus.ld_ready  = !w_full;
    assign bus.alu_ready = !w_full && !bus.ld_valid;
    assign w_ld_acc      = bus.ld_valid && !w_full;
    assign w_alu_acc     = bus.alu_valid && !w_full && !bus.ld_valid;

    // Select the winning request payload.
    always_comb begin
        w_req.rd   = bus.alu_rd;
        w_req.data = bus.alu_data;
        if (bus.ld_valid) begin
            w_req.rd   = bus.ld_rd;
            w_req.data = bus.ld_data;
        end
    end

    // Writes to x0 complete the handshake but are dropped here.
    assign w_wr  = (w_ld_acc || w_alu_acc) && (w_req.rd != '0);
    assign w_pop = !bus.hold && !w_empty;
`ifdef REG_WRITEBACK_BYPASS_EN
    assign w_byp = w_wr && w_empty && !bus.hold;
`else
    assign w_byp = 1'b0;
`endif
    assign w_push = w_wr && !w_byp;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_mem   (w_fifo_mem),
        .o_valid (w_fifo_valid)
    );

    // Destinations currently buffered in the FIFO.
    always_comb begin
        w_fifo_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_fifo_valid[i]) w_fifo_mask = w_fifo_mask | onehot_rd(w_fifo_mem[i].rd);
        end
    end

    // Output stage and pending mask. Next pending = buffered entries plus the
    // incoming write; a popped head moves into the output stage and stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_store   <= '0;
            r_data    <= '0;
            r_pending <= '0;
        end else begin
            r_store   <= '0;
            r_pending <= w_fifo_mask | (w_wr ? onehot_rd(w_req.rd) : '0);
            if (w_pop) begin
                r_store <= onehot_rd(w_head.rd);
                r_data  <= w_head.data;
            end else if (w_byp) begin
                r_store <= onehot_rd(w_req.rd);
                r_data  <= w_req.data;
            end
        end
    end

    assign bus.store   = r_store;
    assign bus.data    = r_data;
    assign bus.pending = r_pending;
    assign bus.count   = w_count;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed vector table, hand-written
// hold/reset/latency sequences, and randomized traffic against a queue model.
module tb_reg_writeback;
    import wb_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_writeback_if #(.DEPTH(DEPTH)) bus ();
    reg_writeback #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                         input logic hold);
        bus.alu_valid = av;  bus.alu_rd = ard; bus.alu_data = adat;
        bus.ld_valid  = lv;  bus.ld_rd  = lrd; bus.ld_data  = ldat;
        bus.hold      = hold;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a queue of writes plus the currently strobed write.
    wb_req_t     mq[$];
    logic [31:0] m_store;
    logic [31:0] m_data;

    function automatic logic [31:0] m_pending();
        logic [31:0] p;
        p = m_store;
        foreach (mq[i]) p = p | (32'(1) << mq[i].rd);
        return p;
    endfunction

    task automatic model_step();
        int      sz;
        logic    full, acc_ld, acc_alu, wr;
        wb_req_t req, head;
        sz      = mq.size();
        full    = (sz == int'(DEPTH));
        acc_ld  = bus.ld_valid && !full;
        acc_alu = bus.alu_valid && !full && !bus.ld_valid;
        req.rd   = acc_ld ? bus.ld_rd : bus.alu_rd;
        req.data = acc_ld ? bus.ld_data : bus.alu_data;
        wr      = (acc_ld || acc_alu) && (req.rd != 5'd0);
        m_store = '0;
        if (!bus.hold && sz > 0) begin
            head    = mq.pop_front();
            m_store = 32'(1) << head.rd;
            m_data  = head.data;
        end
`ifdef REG_WRITEBACK_BYPASS_EN
        if (wr && sz == 0 && !bus.hold) begin
            m_store = 32'(1) << req.rd;
            m_data  = req.data;
            wr      = 1'b0;
        end
`endif
        if (wr) mq.push_back(req);
    endtask

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] adat;
        logic        lv;  logic [4:0] lrd; logic [31:0] ldat;
        logic        hold;
        logic        e_ar; logic e_lr;
        logic [31:0] e_store; logic [31:0] e_data; logic [2:0] e_cnt; logic [31:0] e_pend;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [31:0] sq_store[$];
        logic [31:0] sq_data[$];
        logic        accepted;

        // Each row: inputs for the cycle, then outputs seen before that cycle's edge.
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0,  32'h0,        3'd0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0,  32'h0,        3'd1, 32'h20};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 3'd0, 32'h20};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0,  32'hDEADBEEF, 3'd0, 32'h0};
        tbl[4]  = '{1'b1, 5'd4, 32'h2,        1'b1, 5'd3, 32'd1, 1'b0, 1'b0, 1'b1, 32'h0,  32'hDEADBEEF, 3'd0, 32'h0};
        tbl[5]  = '{1'b1, 5'd4, 32'h2,        1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0,  32'hDEADBEEF, 3'd1, 32'h8};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h8,  32'h1,        3'd1, 32'h18};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h2,        3'd0, 32'h10};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0,  32'h2,        3'd0, 32'h0};
        tbl[9]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0,  32'h2,        3'd0, 32'h0};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0,  32'h2,        3'd0, 32'h0};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0,  32'h2,        3'd0, 32'h0};
        tbl[12] = '{1'b1, 5'd7, 32'hA,        1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0,  32'h2,        3'd0, 32'h0};
        tbl[13] = '{1'b1, 5'd7, 32'hB,        1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0,  32'h2,        3'd1, 32'h80};
        tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h80, 32'hA,        3'd1, 32'h80};
        tbl[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h80, 32'hB,        3'd0, 32'h80};
        tbl[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0,  32'hB,        3'd0, 32'h0};

        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("reset_store",   64'(bus.store),   64'd0);
        check("reset_data",    64'(bus.data),    64'd0);
        check("reset_pending", 64'(bus.pending), 64'd0);
        check("reset_count",   64'(bus.count),   64'd0);
        reset = 1'b0;
        tick();

`ifndef REG_WRITEBACK_BYPASS_EN
        // Directed table: single write, arbitration, x0 drop, same-rd ordering.
        for (int r = 0; r < 17; r++) begin
            drive(tbl[r].av, tbl[r].ard, tbl[r].adat, tbl[r].lv, tbl[r].lrd, tbl[r].ldat, tbl[r].hold);
            @(negedge clk);
            check($sformatf("tbl%0d_alu_ready", r), 64'(bus.alu_ready), 64'(tbl[r].e_ar));
            check($sformatf("tbl%0d_ld_ready", r),  64'(bus.ld_ready),  64'(tbl[r].e_lr));
            check($sformatf("tbl%0d_store", r),     64'(bus.store),     64'(tbl[r].e_store));
            check($sformatf("tbl%0d_data", r),      64'(bus.data),      64'(tbl[r].e_data));
            check($sformatf("tbl%0d_count", r),     64'(bus.count),     64'(tbl[r].e_cnt));
            check($sformatf("tbl%0d_pending", r),   64'(bus.pending),   64'(tbl[r].e_pend));
            tick();
        end
`endif

        // Hold: fill to DEPTH, fifth write stalls, release drains in order.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'(100 + i), 1'b0, 5'd0, 32'd0, 1'b1);
            @(negedge clk);
            check($sformatf("hold_fill%0d_ready", i), 64'(bus.alu_ready), 64'd1);
            check($sformatf("hold_fill%0d_store", i), 64'(bus.store), 64'd0);
            tick();
        end
        drive(1'b1, 5'd5, 32'd105, 1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        check("hold_full_count", 64'(bus.count), 64'd4);
        check("hold_full_ready", 64'(bus.alu_ready), 64'd0);
        check("hold_full_ld_ready", 64'(bus.ld_ready), 64'd0);
        tick();
        bus.hold = 1'b0;
        @(negedge clk);
        check("hold_release_ready", 64'(bus.alu_ready), 64'd0);
        check("hold_release_store", 64'(bus.store), 64'd0);
        tick();
        accepted = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.store != '0) begin
                sq_store.push_back(bus.store);
                sq_data.push_back(bus.data);
            end
            if (bus.alu_valid && bus.alu_ready) accepted = 1'b1;
            tick();
            if (accepted) bus.alu_valid = 1'b0;
        end
        check("hold_fifth_accepted", 64'(accepted), 64'd1);
        check("hold_strobe_count", 64'(sq_store.size()), 64'd5);
        for (int j = 0; j < 5; j++) begin
            if (j < sq_store.size()) begin
                check($sformatf("hold_order%0d_store", j), 64'(sq_store[j]), 64'(32'(1) << (j + 1)));
                check($sformatf("hold_order%0d_data", j),  64'(sq_data[j]),  64'(101 + j));
            end
        end

        // Reset with three buffered writes discards them.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(9 + i), 32'(200 + i), 1'b0, 5'd0, 32'd0, 1'b1);
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        check("prereset_count",   64'(bus.count),   64'd3);
        check("prereset_pending", 64'(bus.pending), 64'h0E00);
        reset    = 1'b1;
        bus.hold = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midreset_count",   64'(bus.count),   64'd0);
        check("midreset_store",   64'(bus.store),   64'd0);
        check("midreset_pending", 64'(bus.pending), 64'd0);
        for (int c = 0; c < 6; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("postreset%0d_store", c), 64'(bus.store), 64'd0);
        end
        tick();

        // Latency of a single write into an empty FIFO.
        drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
`ifdef REG_WRITEBACK_BYPASS_EN
        check("lat_edge1_store", 64'(bus.store), 64'h40);
        check("lat_edge1_count", 64'(bus.count), 64'd0);
        tick();
        @(negedge clk);
        check("lat_edge2_store", 64'(bus.store), 64'd0);
`else
        check("lat_edge1_store", 64'(bus.store), 64'd0);
        check("lat_edge1_count", 64'(bus.count), 64'd1);
        tick();
        @(negedge clk);
        check("lat_edge2_store", 64'(bus.store), 64'h40);
        check("lat_edge2_data",  64'(bus.data),  64'h66);
`endif
        tick();

        // Randomized traffic against the queue model.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mq.delete();
        m_store = '0;
        m_data  = '0;
        for (int n = 0; n < 500; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 3) == 0));
            @(negedge clk);
            check("rnd_alu_ready", 64'(bus.alu_ready), 64'(mq.size() < int'(DEPTH) && !bus.ld_valid));
            check("rnd_ld_ready",  64'(bus.ld_ready),  64'(mq.size() < int'(DEPTH)));
            check("rnd_store",     64'(bus.store),     64'(m_store));
            check("rnd_data",      64'(bus.data),      64'(m_data));
            check("rnd_pending",   64'(bus.pending),   64'(m_pending()));
            check("rnd_count",     64'(bus.count),     64'(mq.size()));
            model_step();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writeback stage directly upstream of the register array.
- Accepts result writes from the ALU and the load unit over valid/ready handshakes and buffers them in a small FIFO.
- Drains one write per cycle onto the shared register data line plus a one-hot per-register store strobe.
- Exports a pending-write mask that decode uses for hazard stalls.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, number of architectural registers; rd width is $clog2(NREGS).
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU write request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_rd  in  $clog2(NREGS)  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load-unit write request.
- ld_ready  out  1  load request accepted this cycle.
- ld_rd  in  $clog2(NREGS)  load destination register.
- ld_data  in  XLEN  load result.
- hold  in  1  freeze the drain; no store strobe is issued while high.
- store  out  NREGS  one-hot register store strobes, registered.
- data  out  XLEN  write data to the registers, registered.
- pending  out  NREGS  bit i set while a write to register i is in the FIFO or the output stage.
- count  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the output stage.

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-high, sampled on the rising edge of clk, with priority over all other activity.
  - Reset empties the FIFO and clears store, data, pending and count to 0.
  - A reset asserted mid-operation discards all buffered writes, so no store strobe follows.
- Arbitration:
  - Fixed priority: the load unit wins over the ALU.
  - At most one enqueue per cycle.
  - ld_ready = !full.
  - alu_ready = !full && !ld_valid.
  - full means count == DEPTH.
  - Ready is combinational from the registered count only. A pop in the same cycle does not relieve full.
- x0 rule: a request with rd == 0 is handshaken (ready as above) but not enqueued, and never produces a store strobe.
- Drain:
  - When hold == 0 and the FIFO is non-empty, pop the head each cycle into the output stage.
  - In that next cycle, store = one-hot(rd) and data = value.
  - Otherwise store = 0 and data holds its last value.
  - store is high for exactly one cycle per write.
- Latency (without the optional feature): a request accepted at edge k into an empty FIFO drives store/data from edge k+1 to edge k+2. The register captures it at edge k+2.
- Simultaneous enqueue and pop: count is unchanged and ordering is preserved (strict FIFO, oldest first).
- Ordering: two writes to the same rd retire in acceptance order, so the last one accepted wins.
- hold:
  - Asserted mid-stream, hold forces store to 0 in the following cycle.
  - The FIFO keeps all entries, and enqueue continues until full.
  - Deasserting hold resumes the drain with the head.
- pending:
  - OR of one-hot(rd) over valid FIFO entries and the output stage while store != 0.
  - Registered, updated on the same edge as the FIFO.
  - Bit 0 is always 0.
- Pointers: wrap modulo DEPTH; count saturates by construction (no overflow or underflow possible).

Optional Feature:
- Macro: REG_WRITEBACK_BYPASS_EN.
- When defined: if the FIFO is empty, hold == 0 and a request with rd != 0 is accepted, it goes straight to the output stage on the same edge. Latency becomes store high from edge k to edge k+1, and count stays 0.
- When undefined: every write passes through the FIFO, with the 2-edge latency above.

Decomposition:
- Package wb_pkg holds:
  - XLEN default;
  - NREGS default;
  - the typedef wb_req_t {rd, data};
  - the function onehot_rd().
- Sub-module wb_fifo (a parameterised synchronous FIFO of wb_req_t with push, pop, full, empty and count) is natural.
- Arbitration, the x0 filter, the output stage and pending stay in reg_writeback.

Test Plan:
1. ALU write rd=5, data=0xDEADBEEF, single cycle -> store==32'h20 and data==0xDEADBEEF for exactly one cycle, 2 edges after acceptance; pending[5] is high until then.
2. ld_valid and alu_valid in the same cycle (ld rd=3 data=1, alu rd=4 data=2) -> ld_ready=1, alu_ready=0; the ALU retries and is accepted next cycle; strobes are rd=3 then rd=4 on consecutive cycles.
3. hold=1, then 5 ALU writes rd=1..5 -> 4 accepted, count==4, alu_ready=0 on the 5th; release hold -> stores rd=1,2,3,4 in order, then 5 is accepted.
4. ALU write rd=0 data=0xFFFFFFFF -> alu_ready=1, count stays 0, store stays 0, pending==0.
5. Two writes rd=7 (0xA, then 0xB) -> two store strobes in order; the last data is 0xB.
6. Reset asserted with count==3 -> next cycle count==0, store==0, pending==0, and no strobes afterwards; with REG_WRITEBACK_BYPASS_EN, a write to an empty FIFO shows its strobe 1 edge after acceptance.
